ip2_scanchain_reg: RTL and testbench

- FW-side shadow and working register for the 768-bit ASIC scan chain.
- Holds the pattern written by software. On load/shift strobes from the IP2 test state machines, presents the pattern bit-serially (`scanchain_reg_bit0`) and counts shifts.
- Captures the chain's serial return (`scan_out_i`) into a readback register and flags a compare result once a full pass completes.

---
 rtl/ip2_scanchain_reg_if.sv | 36 +++
 rtl/ip2_scanchain_reg.sv | 91 +++++++++
 tb/tb_ip2_scanchain_reg.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ip2_scanchain_reg_if.sv
// Bus bundle between the IP2 test state machines / software side and the
// scan-chain shadow/working register block.
interface ip2_scanchain_reg_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 11,
    parameter int ADDR_W = 5
);
    logic              enable;
    logic              cfg_wr_en;
    logic [ADDR_W-1:0] cfg_wr_addr;
    logic [WORD_W-1:0] cfg_wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              scanchain_reg_load;
    logic              scanchain_reg_shift;
    logic              scan_out_i;
    logic              scanchain_reg_bit0;
    logic [CNT_W-1:0]  scanchain_reg_shift_cnt;
    logic [CNT_W-1:0]  scanchain_reg_shift_cnt_max;
    logic              pass_done;
    logic              pass_error;

    modport slave (
        input  enable, cfg_wr_en, cfg_wr_addr, cfg_wr_data, rd_addr,
               scanchain_reg_load, scanchain_reg_shift, scan_out_i,
        output rd_data, scanchain_reg_bit0, scanchain_reg_shift_cnt,
               scanchain_reg_shift_cnt_max, pass_done, pass_error
    );

    modport master (
        output enable, cfg_wr_en, cfg_wr_addr, cfg_wr_data, rd_addr,
               scanchain_reg_load, scanchain_reg_shift, scan_out_i,
        input  rd_data, scanchain_reg_bit0, scanchain_reg_shift_cnt,
               scanchain_reg_shift_cnt_max, pass_done, pass_error
    );
endinterface

// File: rtl/ip2_scanchain_reg.sv
// Shadow, working and capture registers for the ASIC scan chain: serialises the
// software pattern, captures the chain return and flags a compare result.
module ip2_scanchain_reg #(
    parameter int SCAN_LEN = 768,
    parameter int WORD_W   = 32,
    parameter int CNT_W    = 11,
    parameter int ADDR_W   = 5
) (
    input  logic               clk,
    input  logic               reset_not,
    ip2_scanchain_reg_if.slave bus
);
    localparam int               N_WORDS = SCAN_LEN / WORD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_LEN);

    logic [SCAN_LEN-1:0] shadow_q, shadow_d;
    logic [SCAN_LEN-1:0] working_q, working_d;
    logic [SCAN_LEN-1:0] capture_q, capture_d;
    logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic                pass_done_q, pass_done_d;
    logic                pass_error_q, pass_error_d;

    always_comb begin
        shadow_d     = shadow_q;
        working_d    = working_q;
        capture_d    = capture_q;
        shift_cnt_d  = shift_cnt_q;
        pass_done_d  = pass_done_q;
        pass_error_d = pass_error_q;
        rd_data_d    = '0;

        // Word decode by loop so addresses beyond the last word match nothing.
        for (int k = 0; k < N_WORDS; k++) begin
            if (bus.cfg_wr_en && (bus.cfg_wr_addr == ADDR_W'(k))) begin
                shadow_d[k*WORD_W +: WORD_W] = bus.cfg_wr_data;
            end
            if (bus.rd_addr == ADDR_W'(k)) begin
                rd_data_d = capture_q[k*WORD_W +: WORD_W];
            end
        end

        if (bus.enable) begin
            if (bus.scanchain_reg_load) begin
                working_d    = shadow_q;
                capture_d    = '0;
                shift_cnt_d  = '0;
                pass_done_d  = 1'b0;
                pass_error_d = 1'b0;
            end else begin
                if (bus.scanchain_reg_shift && (shift_cnt_q < CNT_MAX)) begin
                    working_d   = {1'b0, working_q[SCAN_LEN-1:1]};
                    capture_d   = {bus.scan_out_i, capture_q[SCAN_LEN-1:1]};
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
                // Compare is taken one cycle after the final shift lands.
                if ((shift_cnt_q == CNT_MAX) && !pass_done_q) begin
                    pass_done_d  = 1'b1;
                    pass_error_d = (capture_q != shadow_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            shadow_q     <= '0;
            working_q    <= '0;
            capture_q    <= '0;
            shift_cnt_q  <= '0;
            rd_data_q    <= '0;
            pass_done_q  <= 1'b0;
            pass_error_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            working_q    <= working_d;
            capture_q    <= capture_d;
            shift_cnt_q  <= shift_cnt_d;
            rd_data_q    <= rd_data_d;
            pass_done_q  <= pass_done_d;
            pass_error_q <= pass_error_d;
        end
    end

    assign bus.rd_data                     = rd_data_q;
    assign bus.scanchain_reg_bit0          = working_q[0];
    assign bus.scanchain_reg_shift_cnt     = shift_cnt_q;
    assign bus.scanchain_reg_shift_cnt_max = CNT_MAX;
    assign bus.pass_done                   = pass_done_q;
    assign bus.pass_error                  = pass_error_q;
endmodule

// File: tb/tb_ip2_scanchain_reg.sv
// Directed self-checking bench for ip2_scanchain_reg: shadow writes, full passes,
// error injection, load/shift priority, enable freeze, async reset, paced shifting.
module tb_ip2_scanchain_reg;
    localparam int SCAN_LEN = 768;
    localparam int WORD_W   = 32;
    localparam int CNT_W    = 11;
    localparam int ADDR_W   = 5;

    typedef enum logic [1:0] {DRV_IDLE, DRV_SHIFT_IN, DRV_DONE} drvState_t;

    logic clk = 1'b0;
    logic reset_not = 1'b0;
    always #5 clk = ~clk;

    ip2_scanchain_reg_if #(.WORD_W(WORD_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

    ip2_scanchain_reg #(
        .SCAN_LEN(SCAN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset_not(reset_not),
        .bus(bus)
    );

    int                  checkCount = 0;
    int                  errorCount = 0;
    int                  pos = 0;
    logic [SCAN_LEN-1:0] shadowM = '0;
    logic [SCAN_LEN-1:0] loadedM = '0;
    drvState_t           drvState = DRV_IDLE;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = addr;
        bus.cfg_wr_data = data;
        tick();
        bus.cfg_wr_en = 1'b0;
        if (int'(addr) < SCAN_LEN / WORD_W) shadowM[int'(addr)*WORD_W +: WORD_W] = data;
    endtask

    task automatic applyStimulus(input logic ld, input logic sh, input logic so);
        bus.scanchain_reg_load  = ld;
        bus.scanchain_reg_shift = sh;
        bus.scan_out_i          = so;
        tick();
        bus.scanchain_reg_load  = 1'b0;
        bus.scanchain_reg_shift = 1'b0;
    endtask

    task automatic loadPattern();
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadedM = shadowM;
        pos = 0;
    endtask

    // Loopback is either the ideal chain (bit0) or the bench model of the pattern.
    task automatic runShifts(input int n, input int flipAt, input bit useModel);
        logic so;
        for (int i = 0; i < n; i++) begin
            if (pos < SCAN_LEN) checkOutput("bit0_seq", 32'(bus.scanchain_reg_bit0), 32'(loadedM[pos]));
            so = useModel ? loadedM[pos] : bus.scanchain_reg_bit0;
            if (pos == flipAt) so = ~so;
            applyStimulus(1'b0, 1'b1, so);
            if (pos < SCAN_LEN) pos++;
        end
        checkOutput("shift_cnt_run", 32'(bus.scanchain_reg_shift_cnt), 32'(pos));
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_wr_addr = '0;
        bus.cfg_wr_data = '0;
        bus.rd_addr = '0;
        bus.scanchain_reg_load = 1'b0;
        bus.scanchain_reg_shift = 1'b0;
        bus.scan_out_i = 1'b0;

        // 1: reset values, pattern load
        #12;
        checkOutput("rst_bit0", 32'(bus.scanchain_reg_bit0), 32'd0);
        checkOutput("rst_cnt", 32'(bus.scanchain_reg_shift_cnt), 32'd0);
        checkOutput("rst_done", 32'(bus.pass_done), 32'd0);
        checkOutput("rst_err", 32'(bus.pass_error), 32'd0);
        checkOutput("rst_rd_data", bus.rd_data, 32'd0);
        reset_not = 1'b1;
        tick();
        for (int k = 0; k < 24; k++) writeWord(ADDR_W'(k), 32'hA5A5_0000 + 32'(k));
        loadPattern();
        bus.rd_addr = 5'd0;
        tick();
        checkOutput("t1_bit0", 32'(bus.scanchain_reg_bit0), 32'd0);
        checkOutput("t1_cnt", 32'(bus.scanchain_reg_shift_cnt), 32'd0);
        checkOutput("t1_done", 32'(bus.pass_done), 32'd0);
        checkOutput("t1_rd_data", bus.rd_data, 32'd0);
        checkOutput("cnt_max", 32'(bus.scanchain_reg_shift_cnt_max), 32'd768);

        // 2: ideal pass
        runShifts(SCAN_LEN, -1, 1'b0);
        checkOutput("t2_cnt", 32'(bus.scanchain_reg_shift_cnt), 32'd768);
        checkOutput("t2_done_early", 32'(bus.pass_done), 32'd0);
        tick();
        checkOutput("t2_done", 32'(bus.pass_done), 32'd1);
        checkOutput("t2_err", 32'(bus.pass_error), 32'd0);
        bus.rd_addr = 5'd5;
        tick();
        checkOutput("t2_rd5", bus.rd_data, 32'hA5A5_0005);

        // 3: corrupted return on shift index 100 lands in word 3 bit 4
        loadPattern();
        checkOutput("t3_done_clr", 32'(bus.pass_done), 32'd0);
        runShifts(SCAN_LEN, 100, 1'b0);
        tick();
        checkOutput("t3_done", 32'(bus.pass_done), 32'd1);
        checkOutput("t3_err", 32'(bus.pass_error), 32'd1);
        bus.rd_addr = 5'd3;
        tick();
        checkOutput("t3_rd3", bus.rd_data, 32'hA5A5_0013);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t3_cnt_sat", 32'(bus.scanchain_reg_shift_cnt), 32'd768);
        tick();
        checkOutput("t3_rd3_hold", bus.rd_data, 32'hA5A5_0013);
        bus.rd_addr = 5'd0;
        tick();
        checkOutput("t3_rd0_hold", bus.rd_data, 32'hA5A5_0000);
        bus.rd_addr = 5'd30;
        tick();
        checkOutput("t3_rd_oob", bus.rd_data, 32'd0);

        // 4: load beats shift in the same cycle
        loadPattern();
        writeWord(5'd0, 32'h1234_5679);
        runShifts(300, -1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        loadedM = shadowM;
        pos = 0;
        checkOutput("t4_cnt", 32'(bus.scanchain_reg_shift_cnt), 32'd0);
        checkOutput("t4_done", 32'(bus.pass_done), 32'd0);
        checkOutput("t4_bit0", 32'(bus.scanchain_reg_bit0), 32'd1);
        runShifts(40, -1, 1'b0);

        // 5: enable freeze, out-of-range write, resume, async reset
        loadPattern();
        runShifts(50, -1, 1'b0);
        bus.enable = 1'b0;
        bus.scanchain_reg_shift = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.scanchain_reg_load = (i == 4);
            tick();
        end
        bus.scanchain_reg_shift = 1'b0;
        bus.scanchain_reg_load = 1'b0;
        checkOutput("t5_cnt_frozen", 32'(bus.scanchain_reg_shift_cnt), 32'd50);
        checkOutput("t5_bit0_frozen", 32'(bus.scanchain_reg_bit0), 32'(loadedM[50]));
        bus.enable = 1'b1;
        writeWord(5'd24, 32'hFFFF_FFFF);
        runShifts(SCAN_LEN - 50, -1, 1'b0);
        tick();
        checkOutput("t5_resume_done", 32'(bus.pass_done), 32'd1);
        checkOutput("t5_resume_err", 32'(bus.pass_error), 32'd0);
        loadPattern();
        runShifts(SCAN_LEN, -1, 1'b1);
        tick();
        checkOutput("t5_model_err", 32'(bus.pass_error), 32'd0);

        loadPattern();
        bus.rd_addr = 5'd23;
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("t5_pre_rd", bus.rd_data, 32'hFFFF_C000);
        checkOutput("t5_pre_bit0", 32'(bus.scanchain_reg_bit0), 32'(loadedM[18]));
        @(posedge clk);
        #3 reset_not = 1'b0;
        #1;
        checkOutput("t5_arst_bit0", 32'(bus.scanchain_reg_bit0), 32'd0);
        checkOutput("t5_arst_cnt", 32'(bus.scanchain_reg_shift_cnt), 32'd0);
        checkOutput("t5_arst_rd", bus.rd_data, 32'd0);
        checkOutput("t5_arst_done", 32'(bus.pass_done), 32'd0);
        checkOutput("t5_arst_err", 32'(bus.pass_error), 32'd0);
        #2 reset_not = 1'b1;
        shadowM = '0;
        tick();

        // 6: paced driver, one strobe every 20 clk
        for (int k = 0; k < 24; k++) writeWord(ADDR_W'(k), 32'h0F0F_1000 + 32'(k * 3));
        loadPattern();
        drvState = DRV_SHIFT_IN;
        while (drvState == DRV_SHIFT_IN) begin
            for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("t6_bit0_hold", 32'(bus.scanchain_reg_bit0), 32'(loadedM[pos]));
            applyStimulus(1'b0, 1'b1, bus.scanchain_reg_bit0);
            pos++;
            checkOutput("t6_bit0_next", 32'(bus.scanchain_reg_bit0),
                        (pos < SCAN_LEN) ? 32'(loadedM[pos]) : 32'd0);
            if (pos == SCAN_LEN) drvState = DRV_DONE;
        end
        checkOutput("t6_cnt_max", 32'(bus.scanchain_reg_shift_cnt), 32'(bus.scanchain_reg_shift_cnt_max));
        checkOutput("t6_cnt", 32'(bus.scanchain_reg_shift_cnt), 32'd768);
        tick();
        checkOutput("t6_err", 32'(bus.pass_error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
